c_layer_seq: RTL and testbench

//  Upstream feeder for a bank of c_neuron instances.
//  - Accepts one input vector (N_INPUTS signed words) over a valid/ready handshake.
//  - Drives the shared z/en/d bus so all neurons accumulate in lockstep.
//  - Captures the neurons' q bits into a registered result word with valid/ready.
//  - Holds one vector in a skid buffer while the previous vector is streamed.

---
 rtl/c_layer_pkg.sv | 23 ++
 rtl/c_vec_skid.sv | 43 ++++
 rtl/c_layer_seq.sv | 148 ++++++++++++++
 tb/tb_c_layer_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c_layer_pkg
// Purpose  : Shared states, default sizes and word type for the c_layer feeder.
// Revision : 1.0 - initial release
// ============================================================================
package c_layer_pkg;

    localparam int C_N_INPUTS = 15;
    localparam int C_DATA_W   = 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ZERO = 3'd1,
        GAP  = 3'd2,
        RUN  = 3'd3,
        CAPT = 3'd4
    } c_seq_state_t;

    typedef logic signed [C_DATA_W-1:0] c_word_t;

endpackage
`default_nettype wire

// File: rtl/c_vec_skid.sv
`default_nettype none
// ============================================================================
// Module   : c_vec_skid
// Purpose  : One-entry vector holding buffer; accepts on valid/ready, drains on pop.
// Revision : 1.0 - initial release
// ============================================================================
module c_vec_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_push;

    // Ready is forced low while reset is held, not just after it.
    assign o_ready = ~r_full & ~rst;
    assign w_push  = i_valid & o_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (w_push) begin
                r_data <= i_data;
            end
            r_full <= w_push | (r_full & ~i_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/c_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : c_layer_seq
// Purpose  : Streams buffered input vectors onto the shared neuron z/en/d bus and
//            captures the neuron q bits into a valid/ready result register.
// Revision : 1.0 - initial release
// ============================================================================
module c_layer_seq
    import c_layer_pkg::*;
#(
    parameter int N_INPUTS  = C_N_INPUTS,
    parameter int DATA_W    = C_DATA_W,
    parameter int N_NEURONS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_INPUTS*DATA_W-1:0]   in_data,
    output logic                         z,
    output logic                         en,
    output logic [DATA_W-1:0]            d,
    input  logic [N_NEURONS-1:0]         q_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_NEURONS-1:0]         out_q
);

    localparam int                 c_cnt_w    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int                 c_vec_w    = N_INPUTS * DATA_W;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N_INPUTS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    c_seq_state_t       r_state;
    c_seq_state_t       w_state_n;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_n;
    logic [c_vec_w-1:0] r_work;
    logic [DATA_W-1:0]  r_d;
    logic [DATA_W-1:0]  w_d_n;
    logic               r_z;
    logic               r_en;
    logic               r_out_valid;
    logic [N_NEURONS-1:0] r_out_q;
    logic               w_full;
    logic               w_pop;
    logic               w_load;
    logic [c_vec_w-1:0] w_skid_data;

    c_vec_skid #(
        .WIDTH (c_vec_w)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_data  (w_skid_data)
    );

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_full) begin
                    w_pop     = 1'b1;
                    w_state_n = ZERO;
                end
            end
            ZERO: begin
                w_cnt_n   = '0;
                w_state_n = GAP;
            end
            GAP: begin
                w_state_n = RUN;
            end
            RUN: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_n = CAPT;
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            CAPT: begin
                // Parking here keeps en low, so the neuron q bits stay frozen.
                if (!r_out_valid || out_ready) begin
                    w_load    = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // d is registered alongside en so each RUN cycle presents work[cnt].
        w_d_n = r_d;
        if (w_state_n == RUN) begin
            w_d_n = r_work[w_cnt_n*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_z     <= 1'b0;
            r_en    <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_z     <= (w_state_n == ZERO);
            r_en    <= (w_state_n == RUN);
            r_d     <= w_d_n;
            if (w_pop) begin
                r_work <= w_skid_data;
            end
        end
    end

    // A drain and reload in the same cycle keeps out_valid high with new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_q     <= q_in;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign z         = r_z;
    assign en        = r_en;
    assign d         = r_d;
    assign out_valid = r_out_valid;
    assign out_q     = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_c_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_layer_seq
// Purpose  : Self-checking bench for c_layer_seq with a behavioural neuron bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_layer_seq;
    import c_layer_pkg::*;

    localparam int N_INPUTS  = C_N_INPUTS;
    localparam int DATA_W    = C_DATA_W;
    localparam int N_NEURONS = 8;
    localparam int VEC_W     = N_INPUTS * DATA_W;
    localparam int LAT       = N_INPUTS + 3;
    localparam int PERIOD    = N_INPUTS + 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [VEC_W-1:0]     in_data = '0;
    logic                 z;
    logic                 en;
    logic [DATA_W-1:0]    d;
    logic [N_NEURONS-1:0] q_in;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [N_NEURONS-1:0] out_q;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int wt   [N_NEURONS];
    int nsum [N_NEURONS];

    logic [N_NEURONS-1:0] exp_q [$];
    logic [N_NEURONS-1:0] act_q [$];
    logic [DATA_W-1:0]    d_log [$];
    int                   z_cyc [$];
    int                   en_rise [$];
    int                   ov_rise [$];
    int                   stall_log [$];
    logic                 en_prev = 1'b0;
    logic                 ov_prev = 1'b0;

    c_layer_seq #(
        .N_INPUTS  (N_INPUTS),
        .DATA_W    (DATA_W),
        .N_NEURONS (N_NEURONS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .z         (z),
        .en        (en),
        .d         (d),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Neuron bank stand-in: clear on z, multiply-accumulate on en.
    always @(posedge clk) begin
        for (int k = 0; k < N_NEURONS; k++) begin
            if (z) nsum[k] <= 0;
            else if (en) nsum[k] <= nsum[k] + int'($signed(d)) * wt[k];
        end
    end

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
        assign q_in[k] = (nsum[k] >= 1024) || (nsum[k] <= -1024);
    end

    // Reference result: whole-vector dot product per neuron, thresholded.
    function automatic logic [N_NEURONS-1:0] ref_q(input logic [VEC_W-1:0] v);
        logic [N_NEURONS-1:0] r;
        c_word_t              w;
        int                   s;
        r = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            s = 0;
            for (int j = 0; j < N_INPUTS; j++) begin
                w = v[j*DATA_W +: DATA_W];
                s = s + int'(w) * wt[k];
            end
            r[k] = (s >= 1024) || (s <= -1024);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(ref_q(in_data));
            if (in_valid && !in_ready) stall_log.push_back(cyc);
            if (z) z_cyc.push_back(cyc);
            if (en) begin
                d_log.push_back(d);
                if (!en_prev) en_rise.push_back(cyc);
            end
            if (out_valid && !ov_prev) ov_rise.push_back(cyc);
            if (out_valid && out_ready) act_q.push_back(out_q);
        end
        en_prev <= en;
        ov_prev <= out_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete(); act_q.delete(); d_log.delete(); z_cyc.delete();
        en_rise.delete(); ov_rise.delete(); stall_log.delete();
    endtask

    task automatic set_weights(input int lo, input int hi);
        for (int k = 0; k < N_NEURONS; k++) wt[k] = lo + int'($urandom_range(0, hi - lo));
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int j = 0; j < N_INPUTS; j++) v[j*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    task automatic send(input logic [VEC_W-1:0] v);
        int t;
        in_valid = 1'b1;
        in_data  = v;
        t = 0;
        while (!in_ready && t < 200) begin
            tick(1);
            t++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (act_q.size() < n && t < 300) begin
            tick(1);
            t++;
        end
        if (act_q.size() < n) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout: got %0d results, required %0d", act_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(2);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0b, required 0", in_ready); end
        n_vec++; if ({z, en} !== 2'b00) begin n_err++; $display("FAIL rst_z_en: got %b, required 00", {z, en}); end
        n_vec++; if (d !== '0) begin n_err++; $display("FAIL rst_d: got %h, required 0", d); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
        n_vec++; if (out_q !== '0) begin n_err++; $display("FAIL rst_out_q: got %h, required 0", out_q); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %0b, required 1", in_ready); end
        tick(1);
        clear_logs();
    endtask

    task automatic test_single();
        logic [VEC_W-1:0] v;
        int lat;
        logic bad;
        set_weights(-20, 20);
        out_ready = 1'b1;
        clear_logs();
        for (int j = 0; j < N_INPUTS; j++) v[j*DATA_W +: DATA_W] = DATA_W'(j + 1);
        send(v);
        wait_results(1);
        tick(3);
        n_vec++; if (z_cyc.size() !== 1) begin n_err++; $display("FAIL single_z_pulses: got %0d, required 1", z_cyc.size()); end
        n_vec++; if (d_log.size() !== N_INPUTS) begin n_err++; $display("FAIL single_en_cycles: got %0d, required %0d", d_log.size(), N_INPUTS); end
        bad = 1'b0;
        for (int j = 0; j < N_INPUTS && j < d_log.size(); j++)
            if (d_log[j] !== DATA_W'(j + 1)) bad = 1'b1;
        n_vec++; if (bad) begin n_err++; $display("FAIL single_d_order: first word got %0d, required 1..%0d in order", d_log.size() > 0 ? d_log[0] : 0, N_INPUTS); end
        lat = (z_cyc.size() > 0 && ov_rise.size() > 0) ? ov_rise[0] - z_cyc[0] : -1;
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL single_latency: got %0d, required %0d", lat, LAT); end
        n_vec++; if (act_q.size() !== 1 || exp_q.size() !== 1 || act_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL single_out_q: got %h (n=%0d), required %h", act_q.size() > 0 ? act_q[0] : 'x, act_q.size(), exp_q.size() > 0 ? exp_q[0] : 'x);
        end
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] vecs [3];
        logic bad;
        set_weights(-3, 3);
        out_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 3; i++) vecs[i] = rand_vec();
        for (int i = 0; i < 3; i++) send(vecs[i]);
        wait_results(3);
        tick(3);
        n_vec++; if (stall_log.size() == 0) begin n_err++; $display("FAIL b2b_stall: got %0d stalled cycles, required >0", stall_log.size()); end
        n_vec++; if (act_q.size() !== 3 || exp_q.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d results, required 3", act_q.size()); end
        for (int i = 0; i < 3 && i < act_q.size() && i < exp_q.size(); i++) begin
            n_vec++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_out_q[%0d]: got %h, required %h", i, act_q[i], exp_q[i]); end
        end
        for (int i = 1; i < 3 && i < en_rise.size(); i++) begin
            n_vec++; if (en_rise[i] - en_rise[i-1] !== PERIOD) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d, required %0d", i, en_rise[i] - en_rise[i-1], PERIOD); end
        end
        for (int i = 0; i < 3; i++) begin
            bad = (d_log.size() < 3 * N_INPUTS);
            for (int j = 0; j < N_INPUTS && !bad; j++)
                if (d_log[i*N_INPUTS + j] !== vecs[i][j*DATA_W +: DATA_W]) bad = 1'b1;
            n_vec++; if (bad) begin n_err++; $display("FAIL b2b_d_words[%0d]: got %0d words logged, required %0d in vector order", i, d_log.size(), 3 * N_INPUTS); end
        end
    endtask

    task automatic test_backpressure();
        logic [N_NEURONS-1:0] q0;
        logic changed;
        int t0;
        int t;
        set_weights(-3, 3);
        out_ready = 1'b0;
        clear_logs();
        t0 = cyc;
        send(rand_vec());
        send(rand_vec());
        t = 0;
        while (!out_valid && t < 100) begin tick(1); t++; end
        q0 = out_q;
        changed = 1'b0;
        while (cyc - t0 < 45) begin
            tick(1);
            if (out_q !== q0) changed = 1'b1;
        end
        n_vec++; if (changed) begin n_err++; $display("FAIL bp_out_q_stable: got %h, required %h held", out_q, q0); end
        n_vec++; if (out_valid !== 1'b1 || en !== 1'b0) begin n_err++; $display("FAIL bp_parked: got out_valid=%0b en=%0b, required 1 0", out_valid, en); end
        n_vec++; if (d_log.size() !== 2 * N_INPUTS) begin n_err++; $display("FAIL bp_en_cycles: got %0d, required %0d", d_log.size(), 2 * N_INPUTS); end
        n_vec++; if (exp_q.size() < 1 || out_q !== exp_q[0] || act_q.size() !== 0) begin
            n_err++; $display("FAIL bp_first_held: got %h (drained %0d), required %h", out_q, act_q.size(), exp_q.size() > 0 ? exp_q[0] : 'x);
        end
        out_ready = 1'b1;
        wait_results(2);
        tick(3);
        n_vec++; if (act_q.size() !== 2 || exp_q.size() !== 2) begin n_err++; $display("FAIL bp_drain_count: got %0d, required 2", act_q.size()); end
        for (int i = 0; i < 2 && i < act_q.size() && i < exp_q.size(); i++) begin
            n_vec++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_drain[%0d]: got %h, required %h", i, act_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [VEC_W-1:0] v;
        int t;
        set_weights(-3, 3);
        out_ready = 1'b1;
        clear_logs();
        v = rand_vec();
        send(v);
        t = 0;
        while (!en && t < 50) begin tick(1); t++; end
        tick(7);
        n_vec++; if (en !== 1'b1 || d !== v[7*DATA_W +: DATA_W]) begin n_err++; $display("FAIL abort_at_word7: got en=%0b d=%h, required 1 %h", en, d, v[7*DATA_W +: DATA_W]); end
        rst = 1'b1;
        #1;
        n_vec++; if ({in_ready, z, en, d, out_valid, out_q} !== '0) begin
            n_err++; $display("FAIL abort_outputs: got rdy=%0b z=%0b en=%0b d=%h ov=%0b q=%h, required all 0", in_ready, z, en, d, out_valid, out_q);
        end
        tick(1);
        rst = 1'b0;
        clear_logs();
        tick(30);
        n_vec++; if (act_q.size() !== 0 || ov_rise.size() !== 0 || d_log.size() !== 0) begin
            n_err++; $display("FAIL abort_silent: got %0d results %0d en cycles, required 0 0", act_q.size(), d_log.size());
        end
        send(rand_vec());
        wait_results(1);
        tick(3);
        n_vec++; if (act_q.size() !== 1 || exp_q.size() !== 1 || act_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL abort_next_vec: got %h (n=%0d), required %h", act_q.size() > 0 ? act_q[0] : 'x, act_q.size(), exp_q.size() > 0 ? exp_q[0] : 'x);
        end
    endtask

    task automatic test_saturate();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < N_NEURONS; k++) wt[k] = 255;
        out_ready = 1'b1;
        clear_logs();
        for (int j = 0; j < N_INPUTS; j++) v[j*DATA_W +: DATA_W] = 9'h100;
        send(v);
        wait_results(1);
        tick(3);
        n_vec++; if (act_q.size() !== 1 || act_q[0] !== 8'hFF) begin
            n_err++; $display("FAIL saturate_out_q: got %h (n=%0d), required ff", act_q.size() > 0 ? act_q[0] : 'x, act_q.size());
        end
    endtask

    task automatic test_drain_reload();
        logic ep;
        int falls;
        int t;
        set_weights(-3, 3);
        out_ready = 1'b0;
        clear_logs();
        send(rand_vec());
        send(rand_vec());
        falls = 0; ep = en; t = 0;
        while (falls < 2 && t < 100) begin
            tick(1);
            if (ep && !en) falls++;
            ep = en;
            t++;
        end
        n_vec++; if (falls !== 2 || out_valid !== 1'b1 || exp_q.size() !== 2 || out_q !== exp_q[0]) begin
            n_err++; $display("FAIL reload_pre: got falls=%0d ov=%0b q=%h, required 2 1 %h", falls, out_valid, out_q, exp_q.size() > 0 ? exp_q[0] : 'x);
        end
        out_ready = 1'b1;
        tick(1);
        n_vec++; if (out_valid !== 1'b1 || exp_q.size() < 2 || out_q !== exp_q[1]) begin
            n_err++; $display("FAIL reload_same_cycle: got ov=%0b q=%h, required 1 %h", out_valid, out_q, exp_q.size() > 1 ? exp_q[1] : 'x);
        end
        tick(1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reload_drained: got ov=%0b, required 0", out_valid); end
        tick(2);
        n_vec++; if (act_q.size() !== 2 || exp_q.size() !== 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
            n_err++; $display("FAIL reload_sequence: got %0d results, required 2 in order", act_q.size());
        end
    endtask

    initial begin
        for (int k = 0; k < N_NEURONS; k++) begin
            wt[k]   = 0;
            nsum[k] = 0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_saturate();
        test_drain_reload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
